conv_window_streamer: RTL and testbench



---
 rtl/conv_window_streamer_if.sv | 36 +++
 rtl/conv_window_streamer.sv | 131 +++++++++++++
 tb/tb_conv_window_streamer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_streamer_if
// Description : Pixel-in / window-out handshake bundle for the window streamer.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_window_streamer_if #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int CH    = 3,
   parameter int PIX_W = 8
);
   logic                         s_valid;
   logic                         s_ready;
   logic                         s_sof;
   logic [CH*PIX_W-1:0]          s_data;
   logic                         m_valid;
   logic                         m_ready;
   logic [9*CH*PIX_W-1:0]        m_window;
   logic [$clog2(IMG_H)-1:0]     m_row;
   logic [$clog2(IMG_W)-1:0]     m_col;
   logic                         m_last;

   // slave: the streamer itself (consumes pixels, produces windows)
   modport slave (
      input  s_valid, s_sof, s_data, m_ready,
      output s_ready, m_valid, m_window, m_row, m_col, m_last
   );

   // master: the environment around the streamer
   modport master (
      output s_valid, s_sof, s_data, m_ready,
      input  s_ready, m_valid, m_window, m_row, m_col, m_last
   );
endinterface
`default_nettype wire

// File: rtl/conv_window_streamer.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_streamer
// Description : Turns a raster pixel stream into packed 3x3xCH valid-mode windows.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_streamer #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int CH    = 3,
   parameter int PIX_W = 8
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   conv_window_streamer_if.slave    bus
);
   localparam int c_DW = CH * PIX_W;
   localparam int c_WW = 9 * c_DW;
   localparam int c_CW = $clog2(IMG_W);
   localparam int c_RW = $clog2(IMG_H);

   localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
   localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
   localparam logic [c_CW-1:0] c_COL_ONE  = c_CW'(1);
   localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);
   localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
   localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);

   logic [c_CW-1:0] r_col;
   logic [c_RW-1:0] r_row;
   logic [c_CW-1:0] w_col;
   logic [c_RW-1:0] w_row;
   logic [c_CW-1:0] w_col_nxt;
   logic [c_RW-1:0] w_row_nxt;

   logic [c_DW-1:0] r_lb0 [IMG_W];
   logic [c_DW-1:0] r_lb1 [IMG_W];
   logic [c_DW-1:0] r_sr  [3][3];
   logic [c_DW-1:0] w_sr_nxt [3][3];
   logic [c_WW-1:0] w_win_nxt;

   logic            w_accept;
   logic            w_emit;

   logic            r_m_valid;
   logic [c_WW-1:0] r_m_window;
   logic [c_RW-1:0] r_m_row;
   logic [c_CW-1:0] r_m_col;
   logic            r_m_last;

   assign bus.s_ready = !r_m_valid || bus.m_ready;
   assign w_accept    = bus.s_valid && bus.s_ready;

   // A start-of-frame beat is always position (0,0), whatever the counters say
   assign w_col = bus.s_sof ? '0 : r_col;
   assign w_row = bus.s_sof ? '0 : r_row;

   assign w_col_nxt = (w_col == c_COL_LAST) ? '0 : w_col + c_COL_ONE;
   assign w_row_nxt = (w_col != c_COL_LAST) ? w_row :
                      (w_row == c_ROW_LAST) ? '0    : w_row + c_ROW_ONE;

   assign w_emit = w_accept && (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         w_sr_nxt[r][0] = r_sr[r][1];
         w_sr_nxt[r][1] = r_sr[r][2];
      end
      w_sr_nxt[0][2] = r_lb1[w_col];
      w_sr_nxt[1][2] = r_lb0[w_col];
      w_sr_nxt[2][2] = bus.s_data;
   end

   always_comb begin
      w_win_nxt = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_win_nxt[(r*3+c)*c_DW +: c_DW] = w_sr_nxt[r][c];
         end
      end
   end

   // Storage only; never observable until rewritten, so it carries no reset
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb1[w_col] <= r_lb0[w_col];
         r_lb0[w_col] <= bus.s_data;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_sr[r][c] <= w_sr_nxt[r][c];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid  <= 1'b0;
         r_m_window <= '0;
         r_m_row    <= '0;
         r_m_col    <= '0;
         r_m_last   <= 1'b0;
      end else if (w_emit) begin
         r_m_valid  <= 1'b1;
         r_m_window <= w_win_nxt;
         r_m_row    <= w_row - c_ROW_ONE;
         r_m_col    <= w_col - c_COL_ONE;
         r_m_last   <= (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
      end else if (bus.m_ready) begin
         r_m_valid  <= 1'b0;
      end
   end

   assign bus.m_valid  = r_m_valid;
   assign bus.m_window = r_m_window;
   assign bus.m_row    = r_m_row;
   assign bus.m_col    = r_m_col;
   assign bus.m_last   = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_streamer
// Description : Scoreboard bench for conv_window_streamer on a 5x4 image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_streamer;
   localparam int IMG_W = 5;
   localparam int IMG_H = 4;
   localparam int CH    = 3;
   localparam int PIX_W = 8;
   localparam int DW    = CH * PIX_W;
   localparam int WW    = 9 * DW;

   typedef struct {
      int               row;
      int               col;
      bit               last;
      logic [WW-1:0]    win;
      int               acc_cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   n_pop;
   int   rdy_mode;
   int   stall_cnt;
   exp_t exp_q[$];

   conv_window_streamer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .PIX_W(PIX_W)) bus ();

   conv_window_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .PIX_W(PIX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] pixel(input int r, input int c);
      logic [DW-1:0] p;
      for (int k = 0; k < CH; k++) p[k*PIX_W +: PIX_W] = 8'((r*16 + c) + k*64);
      return p;
   endfunction

   // Reference: the window centred on (r-1,c-1) is just the 3x3 image patch
   function automatic exp_t make_exp(input int r, input int c, input int acc);
      exp_t e;
      logic [DW-1:0] p;
      e.row = r - 1;
      e.col = c - 1;
      e.last = (r == IMG_H-1) && (c == IMG_W-1);
      e.acc_cyc = acc;
      e.win = '0;
      for (int wr = 0; wr < 3; wr++) begin
         for (int wc = 0; wc < 3; wc++) begin
            p = pixel(r - 2 + wr, c - 2 + wc);
            e.win[(wr*3+wc)*DW +: DW] = p;
         end
      end
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the beat is taken
   task automatic send_pix(input int r, input int c, input bit sof, input int idle_pct);
      int guard;
      bit taken;
      while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
         bus.s_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_sof   = sof;
      bus.s_data  = pixel(r, c);
      guard = 0;
      taken = 1'b0;
      while (!taken) begin
         @(negedge clk);
         if (bus.s_ready) begin
            taken = 1'b1;
            if (r >= 2 && c >= 2) exp_q.push_back(make_exp(r, c, cyc));
         end else if (guard > 200) begin
            chk("s_ready_timeout", {255'd0, bus.s_ready}, 256'd1);
            break;
         end
         guard++;
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
   endtask

   task automatic send_frame(input int idle_pct, input bit sof_first);
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++)
            send_pix(r, c, sof_first && r == 0 && c == 0, idle_pct);
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus.m_valid) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk({name, "_drained"}, exp_q.size(), 0);
      repeat (3) begin @(posedge clk); #1; end
      chk({name, "_idle_valid"}, {255'd0, bus.m_valid}, 256'd0);
   endtask

   // Ready generator
   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = 1'($urandom_range(1));
            2:       bus.m_ready = 1'b0;
            default: bus.m_ready = (stall_cnt >= 5);
         endcase
      end
   end

   // Monitor: pops expected windows on every output handshake
   initial begin
      exp_t          e;
      bit            prev_hold;
      logic [WW-1:0] h_win;
      int            h_row, h_col;
      bit            h_last;
      prev_hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || !bus.m_valid) begin
            prev_hold = 1'b0;
            continue;
         end
         if (prev_hold) begin
            chk("hold_window", bus.m_window, h_win);
            chk("hold_row", bus.m_row, h_row);
            chk("hold_col", bus.m_col, h_col);
            chk("hold_last", bus.m_last, h_last);
         end
         if (bus.m_ready) begin
            prev_hold = 1'b0;
            chk("window_expected", {255'd0, exp_q.size() > 0}, 256'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_pop++;
               chk("win_row", bus.m_row, e.row);
               chk("win_col", bus.m_col, e.col);
               chk("win_last", bus.m_last, e.last);
               chk("win_data", bus.m_window, e.win);
               if (rdy_mode == 0) chk("win_latency", cyc, e.acc_cyc + 1);
               if (e.row == 1 && e.col == 1) begin
                  chk("w11_e000", bus.m_window[0   +: 8], 8'h00);
                  chk("w11_e110", bus.m_window[96  +: 8], 8'h11);
                  chk("w11_e220", bus.m_window[192 +: 8], 8'h22);
                  chk("w11_e222", bus.m_window[208 +: 8], 8'hA2);
               end
               if (e.row == 2 && e.col == 3) chk("w23_e001", bus.m_window[8 +: 8], 8'h52);
            end
         end else begin
            prev_hold = 1'b1;
            h_win  = bus.m_window;
            h_row  = int'(bus.m_row);
            h_col  = int'(bus.m_col);
            h_last = bus.m_last;
            if (rdy_mode == 3) begin
               stall_cnt++;
               chk("stall_s_ready", {255'd0, bus.s_ready}, 256'd0);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      n_checks = 0; n_fail = 0; n_pop = 0; rdy_mode = 0; stall_cnt = 0;
      bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.s_data = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst_m_valid",  {255'd0, bus.m_valid}, 256'd0);
      chk("rst_m_window", bus.m_window, 256'd0);
      chk("rst_m_row",    bus.m_row, 256'd0);
      chk("rst_m_col",    bus.m_col, 256'd0);
      chk("rst_m_last",   {255'd0, bus.m_last}, 256'd0);
      chk("rst_s_ready",  {255'd0, bus.s_ready}, 256'd1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Continuous streaming, always ready
      p0 = n_pop;
      send_frame(0, 1'b1);
      drain("s1");
      chk("s1_count", n_pop - p0, 6);

      // Stall the first window for five cycles
      p0 = n_pop; stall_cnt = 0; rdy_mode = 3;
      send_frame(0, 1'b0);
      drain("s3");
      chk("s3_stall_cycles", stall_cnt, 5);
      chk("s3_count", n_pop - p0, 6);
      rdy_mode = 0;

      // Random gaps on both sides, three frames back to back
      p0 = n_pop; rdy_mode = 1;
      repeat (3) send_frame(50, 1'b1);
      drain("s4");
      chk("s4_count", n_pop - p0, 18);
      rdy_mode = 0;

      // Partial frame resynchronised by start-of-frame at raster (2,1)
      p0 = n_pop;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < IMG_W; c++) send_pix(r, c, r == 0 && c == 0, 0);
      send_pix(2, 0, 1'b0, 0);
      send_frame(0, 1'b1);
      drain("s5");
      chk("s5_count", n_pop - p0, 6);

      // Reset while window (1,3) is pending
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < IMG_W; c++) send_pix(r, c, r == 0 && c == 0, 0);
      rdy_mode = 2;
      @(negedge clk); #1;
      chk("s6_pending_valid", {255'd0, bus.m_valid}, 256'd1);
      chk("s6_pending_row", bus.m_row, 256'd1);
      chk("s6_pending_col", bus.m_col, 256'd3);
      rst_n = 1'b0;
      #1;
      chk("s6_rst_m_valid", {255'd0, bus.m_valid}, 256'd0);
      chk("s6_rst_s_ready", {255'd0, bus.s_ready}, 256'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      rdy_mode = 0;
      @(posedge clk); #1;
      p0 = n_pop;
      send_frame(0, 1'b0);
      drain("s6");
      chk("s6_count", n_pop - p0, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
